set_assoc_wb_cache: RTL and testbench
=====================================

// Module: set_assoc_wb_cache
// PURPOSE
//  Parametrised N-way (1 or 2) set-associative data cache with multi-word blocks.
//  Write-back, write-allocate policy; LRU replacement.
//  Sits between the CPU load/store stage and main memory.
//  Hits complete in the same cycle. Misses stall the CPU while a word-serial FSM
//  writes back the dirty victim and refills the block.
// PARAMETERS
//  ADDRESS_WIDTH  32    byte address width
//  DATA_WIDTH     32    word width; power of 2, >=8
//  CACHE_SIZE     1024  data capacity in bytes
//  BLOCK_WORDS    4     words per block; power of 2, >=1
//  NUM_WAYS       2     associativity; 1 or 2 only
// PORTS
//  clk_i           in   1    clock
//  rst_i           in   1    synchronous active-high reset
//  AddressPort_i   in   AW   CPU byte address; word offset bits ignored (word-aligned only)
//  WriteData_i     in   DW   CPU store data
//  MemRead_i       in   1    CPU load request
//  MemWrite_i      in   1    CPU store request; wins if both read and write are set
//  ReadData_o      out  DW   load data; valid when (hit_o|resp) & ~stall_o
//  hit_o           out  1    request hit in the cycle it was presented
//  stall_o         out  1    CPU must hold its request stable while high
//  MemAddr_o       out  AW   word-aligned memory beat address
//  MemWriteData_o  out  DW   write-back beat data
//  MemReq_o        out  1    memory beat request
//  MemWe_o         out  1    1 = write beat, 0 = read beat
//  MemReadData_i   in   DW   refill beat data
//  MemValid_i      in   1    beat completes this cycle (ack)
// BEHAVIOUR
//  Address split
//   offset = log2(BLOCK_WORDS*DW/8) bits
//   sets   = CACHE_SIZE / (BLOCK_WORDS*DW/8*NUM_WAYS)
//   index  = log2(sets) bits; tag = remaining bits.
//  State per line: valid, dirty, tag, data[BLOCK_WORDS]. State per set: 1 LRU bit (unused if NUM_WAYS=1).
//  Reset (sync): all valid/dirty/LRU bits cleared; FSM to IDLE.
//   Outputs after reset: MemReq_o=0, MemWe_o=0, stall_o=0, hit_o=0, ReadData_o=0.
//   Reset mid-transfer aborts the transfer; MemReq_o=0 from the next cycle.
//  IDLE, req active (MemRead_i|MemWrite_i)
//   Hit
//    Combinational: hit_o=1, stall_o=0, ReadData_o=hit word.
//    At the edge: a store writes the word and sets dirty; LRU marks the hit way as MRU.
//   Miss
//    Combinational: hit_o=0, stall_o=1.
//    Victim selection: first invalid way (way0 first), otherwise the LRU way.
//    Victim valid & dirty -> WB, otherwise -> REFILL. Miss address and victim are latched.
//  IDLE, no req: all outputs 0; ReadData_o=0.
//  WB
//   MemReq_o=1, MemWe_o=1, MemAddr_o = {victim tag, index, beat, 0}, beat counts 0..BLOCK_WORDS-1.
//   Beat advances only on MemValid_i. After the last beat: clear dirty -> REFILL.
//  REFILL
//   MemReq_o=1, MemWe_o=0, MemAddr_o = {miss tag, index, beat, 0}.
//   On each MemValid_i, store MemReadData_i into the victim word[beat].
//   After the last beat: valid=1, dirty=0, tag=miss tag -> RESP.
//  RESP (1 cycle)
//   stall_o=0, hit_o=0. Access served from the refilled line: a load drives ReadData_o; a store writes and sets dirty.
//   LRU updated. -> IDLE.
//  stall_o=1 throughout WB and REFILL. MemReq_o=0 outside WB/REFILL.
//  MemValid_i while MemReq_o=0 is ignored.
//  Memory latency is unbounded: the FSM waits indefinitely.
//  BLOCK_WORDS=1: single beat each phase. NUM_WAYS=1: degenerates to direct-mapped; LRU unused.
//  Read/write in the same cycle: treated as a write; no error flagged.
// STRUCTURE
//  Package cache_pkg: cache_state_e {IDLE,WB,REFILL,RESP} typedef.
//   Also address-field width functions (offset/index/tag from parameters).
//  Sub-module cache_tag_store: per-way valid/dirty/tag arrays and LRU bits.
//   Gives combinational hit/way lookup and victim select.
//   Data array and FSM stay in the top module.
// TESTING (defaults: 32 sets, 16-byte blocks; 0x000/0x200/0x400 share set 0)
//  Cold load 0x000, memory returns 0xA0..0xA3 -> stall for 4 read beats (0x0,0x4,0x8,0xC).
//   Then RESP ReadData_o=0xA0. A later load of 0x008 -> hit_o=1, data 0xA2.
//  Store 0xDEAD to 0x004 (hit) -> no stall. Load 0x004 -> 0xDEAD, hit_o=1. No memory traffic.
//  Load 0x200, then 0x400 with 0x000 dirty and LRU -> 4 write beats to 0x000..0x00C.
//   Word 1 = 0xDEAD, then 4 refill beats from 0x400. 0x200 still hits.
//  MemValid_i held low 20 cycles mid-refill -> stall_o held, beat index unchanged, MemAddr_o stable.
//  rst_i pulsed during beat 2 of refill -> next cycle MemReq_o=0, stall_o=0.
//   Load 0x000 then misses.
//  BLOCK_WORDS=1, NUM_WAYS=1 build: 0x000 then 0x400 (same line) evicts.
//   0x000 misses again; write-back occurs only if the line is dirty.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared FSM state type and address-field width helpers for the write-back cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, WB, REFILL, RESP} cache_state_e;

  function automatic int offset_w(input int block_words, input int data_width);
    return $clog2(block_words * data_width / 8);
  endfunction

  function automatic int index_w(input int cache_size, input int block_words,
                                 input int data_width, input int num_ways);
    return $clog2(cache_size / (block_words * data_width / 8 * num_ways));
  endfunction

  function automatic int tag_w(input int addr_width, input int cache_size, input int block_words,
                               input int data_width, input int num_ways);
    return addr_width - offset_w(block_words, data_width)
           - index_w(cache_size, block_words, data_width, num_ways);
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Per-way valid/dirty/tag arrays plus per-set LRU bit; combinational lookup and victim choice.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int SETS     = 32,
  parameter int IDX_W    = 5,
  parameter int TAG_W    = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic             hit_way,
  output logic             victim_way,
  output logic             victim_dirty,
  output logic [TAG_W-1:0] victim_tag,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_way,
  input  logic             touch_en,
  input  logic             set_dirty_en,
  input  logic             clr_dirty_en,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag
);

  logic [SETS-1:0]  valid_q [NUM_WAYS];
  logic [SETS-1:0]  dirty_q [NUM_WAYS];
  logic [TAG_W-1:0] tag_q   [NUM_WAYS][SETS];
  logic [SETS-1:0]  lru_q;

  // Invalid ways are preferred as victims, lowest way first; otherwise the LRU way.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w][lookup_idx] && tag_q[w][lookup_idx] == lookup_tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
    victim_way = (NUM_WAYS == 2) ? lru_q[lookup_idx] : 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][lookup_idx]) victim_way = 1'(w);
    end
    victim_dirty = valid_q[victim_way][lookup_idx] && dirty_q[victim_way][lookup_idx];
    victim_tag   = tag_q[victim_way][lookup_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[upd_way][upd_idx] <= 1'b1;
        dirty_q[upd_way][upd_idx] <= 1'b0;
      end
      if (set_dirty_en) dirty_q[upd_way][upd_idx] <= 1'b1;
      if (clr_dirty_en) dirty_q[upd_way][upd_idx] <= 1'b0;
      if (touch_en)     lru_q[upd_idx] <= ~upd_way;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) tag_q[upd_way][upd_idx] <= fill_tag;
  end

endmodule

// File: rtl/set_assoc_wb_cache.sv
// Write-back, write-allocate set-associative data cache with a word-serial miss FSM.
module set_assoc_wb_cache
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CACHE_SIZE    = 1024,
  parameter int BLOCK_WORDS   = 4,
  parameter int NUM_WAYS      = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] AddressPort_i,
  input  logic [DATA_WIDTH-1:0]    WriteData_i,
  input  logic                     MemRead_i,
  input  logic                     MemWrite_i,
  output logic [DATA_WIDTH-1:0]    ReadData_o,
  output logic                     hit_o,
  output logic                     stall_o,
  output logic [ADDRESS_WIDTH-1:0] MemAddr_o,
  output logic [DATA_WIDTH-1:0]    MemWriteData_o,
  output logic                     MemReq_o,
  output logic                     MemWe_o,
  input  logic [DATA_WIDTH-1:0]    MemReadData_i,
  input  logic                     MemValid_i
);

  localparam int AW     = ADDRESS_WIDTH;
  localparam int OFF_W  = offset_w(BLOCK_WORDS, DATA_WIDTH);
  localparam int IDX_W  = index_w(CACHE_SIZE, BLOCK_WORDS, DATA_WIDTH, NUM_WAYS);
  localparam int TAG_W  = tag_w(AW, CACHE_SIZE, BLOCK_WORDS, DATA_WIDTH, NUM_WAYS);
  localparam int SETS   = 1 << IDX_W;
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int WSEL_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  function automatic logic [AW-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                              input logic [IDX_W-1:0] i,
                                              input logic [WSEL_W-1:0] b);
    return (AW'(t) << (OFF_W + IDX_W)) | (AW'(i) << OFF_W)
           | ((AW'(b) & AW'(BLOCK_WORDS - 1)) << BYTE_W);
  endfunction

  cache_state_e      state_q, state_d;
  logic [WSEL_W-1:0] beat_q;
  logic              vway_q;
  logic [TAG_W-1:0]  vtag_q, mtag_q;
  logic [IDX_W-1:0]  midx_q;
  logic [WSEL_W-1:0] mword_q;
  logic [DATA_WIDTH-1:0] data_q [NUM_WAYS][SETS][BLOCK_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] word;
  logic              req, last_beat;
  logic              lk_hit, lk_way, victim_way, victim_dirty;
  logic [TAG_W-1:0]  victim_tag;

  logic              dw_en, dw_way;
  logic [IDX_W-1:0]  dw_idx;
  logic [WSEL_W-1:0] dw_word;
  logic [DATA_WIDTH-1:0] dw_data;
  logic              upd_way, touch_en, set_dirty_en, clr_dirty_en, fill_en;
  logic [IDX_W-1:0]  upd_idx;
  logic              latch_miss, beat_adv;

  assign idx       = IDX_W'(AddressPort_i >> OFF_W);
  assign tag       = TAG_W'(AddressPort_i >> (OFF_W + IDX_W));
  assign word      = WSEL_W'((AddressPort_i >> BYTE_W) & AW'(BLOCK_WORDS - 1));
  assign req       = MemRead_i | MemWrite_i;
  assign last_beat = (beat_q == WSEL_W'(BLOCK_WORDS - 1));

  cache_tag_store #(
    .NUM_WAYS(NUM_WAYS), .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)
  ) u_tags (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lookup_idx  (idx),
    .lookup_tag  (tag),
    .hit         (lk_hit),
    .hit_way     (lk_way),
    .victim_way  (victim_way),
    .victim_dirty(victim_dirty),
    .victim_tag  (victim_tag),
    .upd_idx     (upd_idx),
    .upd_way     (upd_way),
    .touch_en    (touch_en),
    .set_dirty_en(set_dirty_en),
    .clr_dirty_en(clr_dirty_en),
    .fill_en     (fill_en),
    .fill_tag    (mtag_q)
  );

  always_comb begin
    state_d        = state_q;
    hit_o          = 1'b0;
    stall_o        = 1'b0;
    ReadData_o     = '0;
    MemReq_o       = 1'b0;
    MemWe_o        = 1'b0;
    MemAddr_o      = '0;
    MemWriteData_o = '0;
    dw_en          = 1'b0;
    dw_way         = vway_q;
    dw_idx         = midx_q;
    dw_word        = mword_q;
    dw_data        = WriteData_i;
    upd_way        = vway_q;
    upd_idx        = midx_q;
    touch_en       = 1'b0;
    set_dirty_en   = 1'b0;
    clr_dirty_en   = 1'b0;
    fill_en        = 1'b0;
    latch_miss     = 1'b0;
    beat_adv       = 1'b0;
    unique case (state_q)
      IDLE: if (req) begin
        if (lk_hit) begin
          hit_o      = 1'b1;
          ReadData_o = data_q[lk_way][idx][word];
          upd_way    = lk_way;
          upd_idx    = idx;
          touch_en   = 1'b1;
          if (MemWrite_i) begin
            dw_en        = 1'b1;
            dw_way       = lk_way;
            dw_idx       = idx;
            dw_word      = word;
            set_dirty_en = 1'b1;
          end
        end else begin
          stall_o    = 1'b1;
          latch_miss = 1'b1;
          state_d    = victim_dirty ? WB : REFILL;
        end
      end
      WB: begin
        stall_o        = 1'b1;
        MemReq_o       = 1'b1;
        MemWe_o        = 1'b1;
        MemAddr_o      = beat_addr(vtag_q, midx_q, beat_q);
        MemWriteData_o = data_q[vway_q][midx_q][beat_q];
        if (MemValid_i) begin
          beat_adv = 1'b1;
          if (last_beat) begin
            clr_dirty_en = 1'b1;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        stall_o   = 1'b1;
        MemReq_o  = 1'b1;
        MemAddr_o = beat_addr(mtag_q, midx_q, beat_q);
        if (MemValid_i) begin
          beat_adv = 1'b1;
          dw_en    = 1'b1;
          dw_word  = beat_q;
          dw_data  = MemReadData_i;
          if (last_beat) begin
            fill_en = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        touch_en = 1'b1;
        if (MemWrite_i) begin
          dw_en        = 1'b1;
          set_dirty_en = 1'b1;
        end else begin
          ReadData_o = data_q[vway_q][midx_q][mword_q];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (beat_adv) beat_q <= last_beat ? '0 : beat_q + WSEL_W'(1);
    end
  end

  // Miss context and line data carry no reset; they are only read after being written.
  always_ff @(posedge clk_i) begin
    if (latch_miss) begin
      vway_q  <= victim_way;
      vtag_q  <= victim_tag;
      midx_q  <= idx;
      mtag_q  <= tag;
      mword_q <= word;
    end
    if (dw_en) data_q[dw_way][dw_idx][dw_word] <= dw_data;
  end

endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Directed bench: default 2-way/4-word cache plus a 1-way/1-word build side by side.
module tb_set_assoc_wb_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata, maddr, mwdata, mrdata;
  logic        mrd, mwr, hit, stall, mreq, mwe, mvalid;
  logic [31:0] d1_addr, d1_wdata, d1_rdata, d1_maddr, d1_mwdata, d1_mrdata;
  logic        d1_rd, d1_wr, d1_hit, d1_stall, d1_mreq, d1_mwe, d1_mvalid;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  set_assoc_wb_cache dut (
    .clk_i(clk), .rst_i(rst), .AddressPort_i(addr), .WriteData_i(wdata),
    .MemRead_i(mrd), .MemWrite_i(mwr), .ReadData_o(rdata), .hit_o(hit),
    .stall_o(stall), .MemAddr_o(maddr), .MemWriteData_o(mwdata), .MemReq_o(mreq),
    .MemWe_o(mwe), .MemReadData_i(mrdata), .MemValid_i(mvalid)
  );

  set_assoc_wb_cache #(.BLOCK_WORDS(1), .NUM_WAYS(1)) dut_dm (
    .clk_i(clk), .rst_i(rst), .AddressPort_i(d1_addr), .WriteData_i(d1_wdata),
    .MemRead_i(d1_rd), .MemWrite_i(d1_wr), .ReadData_o(d1_rdata), .hit_o(d1_hit),
    .stall_o(d1_stall), .MemAddr_o(d1_maddr), .MemWriteData_o(d1_mwdata), .MemReq_o(d1_mreq),
    .MemWe_o(d1_mwe), .MemReadData_i(d1_mrdata), .MemValid_i(d1_mvalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_refill(input logic [31:0] base, input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      #1;
      vec++;
      if ({mreq, mwe, stall, maddr} !== {3'b101, base + 32'(4 * i)}) begin
        err++;
        $display("FAIL refill beat %0d: req/we/stall/addr=%b%b%b %h want 101 %h",
                 i, mreq, mwe, stall, maddr, base + 32'(4 * i));
      end
      mrdata = d0 + 32'(i);
      mvalid = 1'b1;
      tick();
      mvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = '0; wdata = '0; mrd = 1'b0; mwr = 1'b0; mrdata = '0; mvalid = 1'b0;
    d1_addr = '0; d1_wdata = '0; d1_rd = 1'b0; d1_wr = 1'b0; d1_mrdata = '0; d1_mvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    vec++;
    if ({mreq, mwe, stall, hit} !== 4'b0000) begin
      err++; $display("FAIL reset ctrl: req/we/stall/hit=%b%b%b%b want 0000", mreq, mwe, stall, hit);
    end
    vec++;
    if (rdata !== 32'h0) begin err++; $display("FAIL reset rdata: got %h want 0", rdata); end
  endtask

  task automatic test_cold_load();
    addr = 32'h000; mrd = 1'b1;
    #1;
    vec++;
    if ({hit, stall} !== 2'b01) begin
      err++; $display("FAIL cold miss: hit/stall=%b%b want 01", hit, stall);
    end
    tick();
    serve_refill(32'h000, 32'hA0);
    #1;
    vec++;
    if ({stall, hit, rdata} !== {2'b00, 32'hA0}) begin
      err++; $display("FAIL cold resp: stall/hit=%b%b data=%h want 00 a0", stall, hit, rdata);
    end
    tick();
    addr = 32'h008;
    #1;
    vec++;
    if ({hit, stall, rdata} !== {2'b10, 32'hA2}) begin
      err++; $display("FAIL hit 008: hit/stall=%b%b data=%h want 10 a2", hit, stall, rdata);
    end
    tick();
    mrd = 1'b0;
  endtask

  task automatic test_store_hit();
    addr = 32'h004; wdata = 32'hDEAD; mwr = 1'b1;
    #1;
    vec++;
    if ({hit, stall, mreq} !== 3'b100) begin
      err++; $display("FAIL store hit: hit/stall/req=%b%b%b want 100", hit, stall, mreq);
    end
    tick();
    mwr = 1'b0; mrd = 1'b1;
    #1;
    vec++;
    if ({hit, stall, mreq, rdata} !== {3'b100, 32'hDEAD}) begin
      err++; $display("FAIL load 004: hit/stall/req=%b%b%b data=%h want 100 dead", hit, stall, mreq, rdata);
    end
    tick();
    mrd = 1'b0;
  endtask

  task automatic test_evict();
    logic [31:0] wb_exp [4];
    wb_exp[0] = 32'hA0; wb_exp[1] = 32'hDEAD; wb_exp[2] = 32'hA2; wb_exp[3] = 32'hA3;
    addr = 32'h200; mrd = 1'b1;
    tick();
    serve_refill(32'h200, 32'hB0);
    #1;
    vec++;
    if (rdata !== 32'hB0) begin err++; $display("FAIL resp 200: got %h want b0", rdata); end
    tick();
    addr = 32'h400;
    #1;
    vec++;
    if (stall !== 1'b1) begin err++; $display("FAIL miss 400: stall=%b want 1", stall); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      vec++;
      if ({mreq, mwe, stall, maddr, mwdata} !== {3'b111, 32'(4 * i), wb_exp[i]}) begin
        err++;
        $display("FAIL wb beat %0d: req/we/stall=%b%b%b addr=%h data=%h want 111 %h %h",
                 i, mreq, mwe, stall, maddr, mwdata, 32'(4 * i), wb_exp[i]);
      end
      mvalid = 1'b1;
      tick();
      mvalid = 1'b0;
    end
    serve_refill(32'h400, 32'hC0);
    #1;
    vec++;
    if (rdata !== 32'hC0) begin err++; $display("FAIL resp 400: got %h want c0", rdata); end
    tick();
    addr = 32'h200;
    #1;
    vec++;
    if ({hit, rdata} !== {1'b1, 32'hB0}) begin
      err++; $display("FAIL rehit 200: hit=%b data=%h want 1 b0", hit, rdata);
    end
    tick();
    mrd = 1'b0;
  endtask

  task automatic test_stall_hold_and_reset();
    logic [31:0] hold_addr;
    addr = 32'h000; mrd = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      mrdata = 32'h50 + 32'(i); mvalid = 1'b1;
      tick();
    end
    mvalid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      hold_addr = maddr;
      vec++;
      if ({stall, mreq, mwe, hold_addr} !== {3'b110, 32'h008}) begin
        err++; $display("FAIL hold cyc %0d: stall/req/we=%b%b%b addr=%h want 110 008",
                        c, stall, mreq, mwe, hold_addr);
      end
      tick();
    end
    rst = 1'b1; mvalid = 1'b1; mrdata = 32'h52;
    tick();
    rst = 1'b0; mvalid = 1'b0; mrd = 1'b0;
    #1;
    vec++;
    if ({mreq, stall} !== 2'b00) begin
      err++; $display("FAIL mid-reset: req/stall=%b%b want 00", mreq, stall);
    end
    mrd = 1'b1;
    #1;
    vec++;
    if ({hit, stall} !== 2'b01) begin
      err++; $display("FAIL post-reset load: hit/stall=%b%b want 01", hit, stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; mrd = 1'b0;
  endtask

  task automatic test_direct_mapped();
    d1_addr = 32'h000; d1_wdata = 32'h11; d1_wr = 1'b1;
    #1;
    vec++;
    if (d1_stall !== 1'b1) begin err++; $display("FAIL dm store miss: stall=%b want 1", d1_stall); end
    tick();
    vec++;
    if ({d1_mreq, d1_mwe, d1_maddr} !== {2'b10, 32'h000}) begin
      err++; $display("FAIL dm refill 000: req/we=%b%b addr=%h want 10 000", d1_mreq, d1_mwe, d1_maddr);
    end
    d1_mrdata = 32'h50; d1_mvalid = 1'b1;
    tick();
    d1_mvalid = 1'b0;
    tick();
    d1_wr = 1'b0; d1_rd = 1'b1; d1_addr = 32'h400;
    #1;
    vec++;
    if ({d1_hit, d1_stall} !== 2'b01) begin
      err++; $display("FAIL dm miss 400: hit/stall=%b%b want 01", d1_hit, d1_stall);
    end
    tick();
    vec++;
    if ({d1_mreq, d1_mwe, d1_maddr, d1_mwdata} !== {2'b11, 32'h000, 32'h11}) begin
      err++; $display("FAIL dm wb: req/we=%b%b addr=%h data=%h want 11 000 11",
                      d1_mreq, d1_mwe, d1_maddr, d1_mwdata);
    end
    d1_mvalid = 1'b1;
    tick();
    vec++;
    if ({d1_mreq, d1_mwe, d1_maddr} !== {2'b10, 32'h400}) begin
      err++; $display("FAIL dm refill 400: req/we=%b%b addr=%h want 10 400", d1_mreq, d1_mwe, d1_maddr);
    end
    d1_mrdata = 32'h77;
    tick();
    d1_mvalid = 1'b0;
    vec++;
    if ({d1_stall, d1_rdata} !== {1'b0, 32'h77}) begin
      err++; $display("FAIL dm resp 400: stall=%b data=%h want 0 77", d1_stall, d1_rdata);
    end
    tick();
    d1_addr = 32'h000;
    #1;
    vec++;
    if ({d1_hit, d1_stall} !== 2'b01) begin
      err++; $display("FAIL dm remiss 000: hit/stall=%b%b want 01", d1_hit, d1_stall);
    end
    tick();
    vec++;
    if ({d1_mreq, d1_mwe, d1_maddr} !== {2'b10, 32'h000}) begin
      err++; $display("FAIL dm clean evict: req/we=%b%b addr=%h want 10 000", d1_mreq, d1_mwe, d1_maddr);
    end
    d1_mrdata = 32'h11; d1_mvalid = 1'b1;
    tick();
    d1_mvalid = 1'b0;
    vec++;
    if (d1_rdata !== 32'h11) begin err++; $display("FAIL dm resp 000: got %h want 11", d1_rdata); end
    tick();
    d1_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_evict();
    test_stall_hold_and_reset();
    test_direct_mapped();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
